// File: rtl/code_lock_pkg.sv
// Shared types and widths for the keypad code lock.
// State encodings are the values driven on state_dbg.
// The timer width covers the longest interval, the lockout time.
package code_lock_pkg;

    localparam int DIGIT_W            = 4;
    localparam int LOCKOUT_CYCLES_MAX = 120_000_000;
    localparam int TIMER_W            = $clog2(LOCKOUT_CYCLES_MAX + 1);

    typedef enum logic [2:0] {
        ST_ENTRY    = 3'd0,
        ST_CHECK    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_PROGRAM  = 3'd3,
        ST_FAIL     = 3'd4,
        ST_LOCKOUT  = 3'd5
    } state_t;

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the unlock, error and lockout intervals.
// zero is decoded combinationally from the count; a load takes effect on the next edge.
// The count holds while en is low and saturates at zero.
module lock_timer
    import code_lock_pkg::*;
(
    input  logic               hwclk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic               zero
);

    logic [TIMER_W-1:0] r_count;

    // Load has priority; otherwise count down while enabled, stopping at zero
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule

// File: rtl/code_lock_fsm.sv
// Code lock controller: collects keypad digits, compares them with the stored code,
// and drives unlock, error and lockout timing plus code reprogramming.
// Outputs are registered from the next state, so they change on the same edge as the state.
module code_lock_fsm
    import code_lock_pkg::*;
#(
    parameter int          CODE_LEN       = 4,
    parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234,
    parameter int          UNLOCK_CYCLES  = 36_000_000,
    parameter int          ERROR_CYCLES   = 6_000_000,
    parameter int          LOCKOUT_CYCLES = 120_000_000,
    parameter int          ENTRY_TIMEOUT  = 60_000_000,
    parameter int          MAX_FAILS      = 3
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic [3:0] button,
    input  logic       bstate,
    input  logic       set_code,
    output logic       unlocked,
    output logic       error,
    output logic       lockout,
    output logic       code_saved,
    output logic [2:0] digit_count,
    output logic [2:0] state_dbg
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int CNT_W  = 4;
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int IDLE_W = $clog2(ENTRY_TIMEOUT + 1);

    // The timer runs N-1 down to 0, so a state that exits on zero lasts exactly N cycles
    localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ERROR_LOAD   = TIMER_W'(ERROR_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_bstate_q;
    logic [CODE_W-1:0]   r_buf;
    logic [CODE_W-1:0]   r_code;
    logic [CNT_W-1:0]    r_count;
    logic [FAIL_W-1:0]   r_fail_cnt;
    logic [IDLE_W-1:0]   r_idle;
    logic                r_unlocked, r_error, r_lockout, r_code_saved;

    logic                w_digit_evt, w_accept, w_complete, w_match, w_last_fail;
    logic                w_timeout, w_clear, w_store;
    logic [CODE_W-1:0]   w_buf_shift;
    logic                w_tmr_load, w_tmr_en, w_tmr_zero;
    logic [TIMER_W-1:0]  w_tmr_val;
    logic                w_unlocked_nxt, w_error_nxt, w_lockout_nxt, w_saved_nxt;

    // A press is taken on the falling edge of the scanner strobe; only digits 1..9 count
    assign w_digit_evt = r_bstate_q & ~bstate;
    assign w_accept    = w_digit_evt && (button != 4'd0) && (button <= 4'd9)
                         && ((r_state == ST_ENTRY) || (r_state == ST_PROGRAM));
    assign w_complete  = w_accept && (r_count == CNT_W'(CODE_LEN - 1));
    assign w_buf_shift = {r_buf[CODE_W-DIGIT_W-1:0], button};
    assign w_match     = (r_buf == r_code);
    assign w_last_fail = ((r_fail_cnt + 1'b1) == FAIL_W'(MAX_FAILS));
    assign w_timeout   = (r_state == ST_ENTRY) && (r_count != '0) && !w_digit_evt
                         && (r_idle == IDLE_W'(ENTRY_TIMEOUT - 1));
    assign w_store     = (r_state == ST_PROGRAM) && set_code && w_complete;
    assign w_clear     = (r_state == ST_CHECK) || w_timeout
                         || ((r_state == ST_UNLOCKED) && set_code)
                         || ((r_state == ST_PROGRAM) && (!set_code || w_complete));

    // The single interval timer is armed from CHECK with the length of the outcome state
    assign w_tmr_load = (r_state == ST_CHECK);
    assign w_tmr_val  = w_match ? UNLOCK_LOAD : (w_last_fail ? LOCKOUT_LOAD : ERROR_LOAD);
    assign w_tmr_en   = ((r_state == ST_UNLOCKED) && !set_code)
                        || (r_state == ST_FAIL) || (r_state == ST_LOCKOUT);

    lock_timer u_timer (
        .hwclk    (hwclk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .en       (w_tmr_en),
        .zero     (w_tmr_zero)
    );

    // State register
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ENTRY;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode; set_code in UNLOCKED wins over timer expiry
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ENTRY:    if (w_complete) w_state_nxt = ST_CHECK;
            ST_CHECK:    w_state_nxt = w_match ? ST_UNLOCKED : (w_last_fail ? ST_LOCKOUT : ST_FAIL);
            ST_UNLOCKED: if (set_code) w_state_nxt = ST_PROGRAM;
                         else if (w_tmr_zero) w_state_nxt = ST_ENTRY;
            ST_PROGRAM:  if (!set_code || w_complete) w_state_nxt = ST_ENTRY;
            ST_FAIL,
            ST_LOCKOUT:  if (w_tmr_zero) w_state_nxt = ST_ENTRY;
            default:     w_state_nxt = ST_ENTRY;
        endcase
    end

    // Output decode from the next state so the registered outputs track the state register
    always_comb begin
        w_unlocked_nxt = (w_state_nxt == ST_UNLOCKED) || (w_state_nxt == ST_PROGRAM);
        w_error_nxt    = (w_state_nxt == ST_FAIL);
        w_lockout_nxt  = (w_state_nxt == ST_LOCKOUT);
        w_saved_nxt    = w_store;
    end

    // Output registers
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_unlocked   <= 1'b0;
            r_error      <= 1'b0;
            r_lockout    <= 1'b0;
            r_code_saved <= 1'b0;
        end else begin
            r_unlocked   <= w_unlocked_nxt;
            r_error      <= w_error_nxt;
            r_lockout    <= w_lockout_nxt;
            r_code_saved <= w_saved_nxt;
        end
    end

    // Strobe delay for falling-edge detection
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) r_bstate_q <= 1'b0;
        else        r_bstate_q <= bstate;
    end

    // Entry buffer and digit count; clearing wins over a digit arriving the same cycle
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '0;
            r_count <= '0;
        end else if (w_clear) begin
            r_buf   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_buf   <= w_buf_shift;
            r_count <= r_count + 1'b1;
        end
    end

    // Stored code, replaced only when a full entry completes in PROGRAM
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n)       r_code <= DEFAULT_CODE[CODE_W-1:0];
        else if (w_store) r_code <= w_buf_shift;
    end

    // Consecutive-mismatch counter, cleared by a match or by entering lockout
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_cnt <= '0;
        end else if (r_state == ST_CHECK) begin
            if (w_match || w_last_fail) r_fail_cnt <= '0;
            else                        r_fail_cnt <= r_fail_cnt + 1'b1;
        end
    end

    // Idle cycles since the last press while a partial entry is pending
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if ((r_state != ST_ENTRY) || (r_count == '0) || w_digit_evt || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign unlocked    = r_unlocked;
    assign error       = r_error;
    assign lockout     = r_lockout;
    assign code_saved  = r_code_saved;
    assign digit_count = (r_count > CNT_W'(7)) ? 3'd7 : r_count[2:0];
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Bench for code_lock_fsm with shortened intervals.
// Each entry pushes its expected outcome (kind, length) to a queue; check_outcome pops and compares.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_code_lock_fsm;

    localparam int K_UNL = 1, K_ERR = 2, K_LCK = 3, K_SAV = 4;
    localparam logic [2:0] S_ENTRY = 3'd0, S_CHECK = 3'd1, S_UNLOCKED = 3'd2, S_PROGRAM = 3'd3;

    typedef struct { int kind; int len; } exp_t;

    logic       hwclk, rst_n, bstate, set_code;
    logic [3:0] button;
    logic       unlocked, error, lockout, code_saved;
    logic [2:0] digit_count, state_dbg;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    logic poke = 1'b0;

    code_lock_fsm #(
        .CODE_LEN(4), .DEFAULT_CODE(32'h0000_1234), .UNLOCK_CYCLES(20),
        .ERROR_CYCLES(5), .LOCKOUT_CYCLES(30), .ENTRY_TIMEOUT(50), .MAX_FAILS(3)
    ) dut (
        .hwclk(hwclk), .rst_n(rst_n), .button(button), .bstate(bstate),
        .set_code(set_code), .unlocked(unlocked), .error(error), .lockout(lockout),
        .code_saved(code_saved), .digit_count(digit_count), .state_dbg(state_dbg)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    function automatic logic ind(input int k);
        case (k)
            K_UNL:   return unlocked;
            K_ERR:   return error;
            K_LCK:   return lockout;
            K_SAV:   return code_saved;
            default: return 1'b0;
        endcase
    endfunction

    task automatic press(input logic [3:0] d);
        button = d;
        bstate = 1'b1;
        repeat (2) @(negedge hwclk);
        bstate = 1'b0;
        @(negedge hwclk);
    endtask

    task automatic enter_code(input logic [15:0] code, input int kind, input int len);
        exp_t e;
        if (kind != 0) begin
            e.kind = kind;
            e.len  = len;
            sb.push_back(e);
        end
        press(code[15:12]);
        press(code[11:8]);
        press(code[7:4]);
        press(code[3:0]);
    endtask

    task automatic wait_unlocked(input string name);
        int n = 0;
        while (!unlocked && n < 10) begin
            @(negedge hwclk);
            n++;
        end
        checks++;
        if (unlocked !== 1'b1) begin
            errors++;
            $display("FAIL %s: unlocked=%b after %0d cycles, required 1", name, unlocked, n);
        end
    endtask

    task automatic check_outcome(input string name);
        int   k = 0, len = 0, n = 0;
        logic stray = 1'b0, poke_bad = 1'b0;
        exp_t e;
        while (k == 0 && n < 20) begin
            if (code_saved)    k = K_SAV;
            else if (unlocked) k = K_UNL;
            else if (error)    k = K_ERR;
            else if (lockout)  k = K_LCK;
            else begin
                @(negedge hwclk);
                n++;
            end
        end
        while (k != 0 && ind(k) && len < 200) begin
            if ($countones({unlocked, error, lockout, code_saved}) > 1) stray = 1'b1;
            if (poke) begin
                if (digit_count !== 3'd0) poke_bad = 1'b1;
                button = 4'd7;
                bstate = ~bstate;
            end
            len++;
            @(negedge hwclk);
        end
        checks++;
        if (state_dbg !== S_ENTRY) begin
            errors++;
            $display("FAIL %s_state_after: state=%0d, required %0d", name, state_dbg, S_ENTRY);
        end
        if (poke) begin
            button = 4'd0;
            bstate = 1'b0;
            @(negedge hwclk);
            checks++;
            if (poke_bad || digit_count !== 3'd0) begin
                errors++;
                $display("FAIL %s_digits_ignored: digit_count=%0d bad=%b, required 0", name, digit_count, poke_bad);
            end
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL %s_exclusive: another indicator was high, required none", name);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_queue: outcome kind=%0d with no expectation queued", name, k);
        end else begin
            e = sb.pop_front();
            if (k !== e.kind || len !== e.len) begin
                errors++;
                $display("FAIL %s_outcome: kind=%0d len=%0d, required kind=%0d len=%0d", name, k, len, e.kind, e.len);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bstate = 1'b0; button = 4'd0; set_code = 1'b0;
        repeat (3) @(negedge hwclk);
        checks++;
        if ({unlocked, error, lockout, code_saved, digit_count, state_dbg} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required all 0",
                     {unlocked, error, lockout, code_saved, digit_count, state_dbg});
        end
        rst_n = 1'b1;
        @(negedge hwclk);
    endtask

    task automatic test_unlock();
        logic [3:0] digs [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        exp_t e;
        e.kind = K_UNL; e.len = 20;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            press(digs[i]);
            checks++;
            if (digit_count !== 3'(i + 1)) begin
                errors++;
                $display("FAIL unlock_count%0d: digit_count=%0d, required %0d", i, digit_count, i + 1);
            end
        end
        checks++;
        if (state_dbg !== S_CHECK || unlocked !== 1'b0) begin
            errors++;
            $display("FAIL unlock_check_state: state=%0d unlocked=%b, required %0d/0", state_dbg, unlocked, S_CHECK);
        end
        @(negedge hwclk);
        checks++;
        if (state_dbg !== S_UNLOCKED || digit_count !== 3'd0) begin
            errors++;
            $display("FAIL unlock_after_check: state=%0d count=%0d, required %0d/0", state_dbg, digit_count, S_UNLOCKED);
        end
        check_outcome("unlock");
    endtask

    task automatic test_lockout();
        enter_code(16'h1235, K_ERR, 5);
        check_outcome("fail1");
        enter_code(16'h1235, K_ERR, 5);
        check_outcome("fail2");
        enter_code(16'h1235, K_LCK, 30);
        poke = 1'b1;
        check_outcome("lockout");
        poke = 1'b0;
    endtask

    task automatic test_entry_timeout();
        enter_code(16'h1299, K_ERR, 5);
        check_outcome("pre_timeout_fail");
        press(4'd1);
        press(4'd2);
        repeat (45) @(negedge hwclk);
        checks++;
        if (digit_count !== 3'd2) begin
            errors++;
            $display("FAIL timeout_early: digit_count=%0d, required 2", digit_count);
        end
        repeat (10) @(negedge hwclk);
        checks++;
        if (digit_count !== 3'd0 || error !== 1'b0 || state_dbg !== S_ENTRY) begin
            errors++;
            $display("FAIL timeout_clear: count=%0d error=%b state=%0d, required 0/0/0", digit_count, error, state_dbg);
        end
        enter_code(16'h5555, K_ERR, 5);
        check_outcome("post_timeout_fail");
        enter_code(16'h1234, K_UNL, 20);
        check_outcome("timeout_unlock");
    endtask

    task automatic test_program_abort();
        int saw_saved = 0;
        enter_code(16'h1234, 0, 0);
        wait_unlocked("abort_unlock");
        set_code = 1'b1;
        @(negedge hwclk);
        press(4'd5);
        press(4'd5);
        checks++;
        if (state_dbg !== S_PROGRAM || digit_count !== 3'd2 || unlocked !== 1'b1) begin
            errors++;
            $display("FAIL abort_program: state=%0d count=%0d unlocked=%b, required %0d/2/1",
                     state_dbg, digit_count, unlocked, S_PROGRAM);
        end
        set_code = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge hwclk);
            if (code_saved) saw_saved++;
        end
        checks++;
        if (saw_saved != 0 || state_dbg !== S_ENTRY || unlocked !== 1'b0 || digit_count !== 3'd0) begin
            errors++;
            $display("FAIL abort_exit: saved=%0d state=%0d unlocked=%b count=%0d, required 0/0/0/0",
                     saw_saved, state_dbg, unlocked, digit_count);
        end
        enter_code(16'h1234, K_UNL, 20);
        check_outcome("abort_unlock_again");
    endtask

    task automatic test_program();
        enter_code(16'h1234, 0, 0);
        wait_unlocked("prog_unlock");
        set_code = 1'b1;
        @(negedge hwclk);
        press(4'd9);
        checks++;
        if (state_dbg !== S_PROGRAM || digit_count !== 3'd1) begin
            errors++;
            $display("FAIL prog_first_digit: state=%0d count=%0d, required %0d/1", state_dbg, digit_count, S_PROGRAM);
        end
        sb.push_back('{kind: K_SAV, len: 1});
        press(4'd8);
        press(4'd7);
        press(4'd6);
        checks++;
        if (code_saved !== 1'b1 || unlocked !== 1'b0) begin
            errors++;
            $display("FAIL prog_saved_lock: code_saved=%b unlocked=%b, required 1/0", code_saved, unlocked);
        end
        check_outcome("code_saved");
        set_code = 1'b0;
        enter_code(16'h1234, K_ERR, 5);
        check_outcome("old_code_rejected");
        enter_code(16'h9876, K_UNL, 20);
        check_outcome("new_code_unlock");
    endtask

    task automatic test_async_reset_and_hold();
        int n = 0;
        enter_code(16'h1235, K_ERR, 5);
        check_outcome("rst_fail1");
        enter_code(16'h1235, K_ERR, 5);
        check_outcome("rst_fail2");
        enter_code(16'h1235, 0, 0);
        while (!lockout && n < 10) begin
            @(negedge hwclk);
            n++;
        end
        repeat (3) @(negedge hwclk);
        checks++;
        if (lockout !== 1'b1) begin
            errors++;
            $display("FAIL rst_reach_lockout: lockout=%b, required 1", lockout);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({unlocked, error, lockout, code_saved, digit_count, state_dbg} !== 10'd0) begin
            errors++;
            $display("FAIL rst_immediate: got %b, required all 0",
                     {unlocked, error, lockout, code_saved, digit_count, state_dbg});
        end
        @(negedge hwclk);
        rst_n = 1'b1;
        @(negedge hwclk);
        enter_code(16'h1234, K_UNL, 20);
        check_outcome("rst_default_code");
        button = 4'd3;
        bstate = 1'b1;
        repeat (100) @(negedge hwclk);
        checks++;
        if (digit_count !== 3'd0) begin
            errors++;
            $display("FAIL hold_no_accept: digit_count=%0d, required 0", digit_count);
        end
        bstate = 1'b0;
        @(negedge hwclk);
        checks++;
        if (digit_count !== 3'd1) begin
            errors++;
            $display("FAIL hold_release: digit_count=%0d, required 1", digit_count);
        end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_lockout();
        test_entry_timeout();
        test_program_abort();
        test_program();
        test_async_reset_and_hold();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/code_lock_fsm.md
Name: code_lock_fsm

Overview:
Consumes the keypad scanner's digit code and press strobe, assembles multi-digit entries and compares them with a stored code. Drives the lock actuator and status LEDs: timed unlock, error flash, and lockout after repeated failures. While unlocked, the stored code can be reprogrammed. Sits directly downstream of the keypad scanner/debouncer on the same hwclk.

Parameters:
CODE_LEN, 4, digits per code (2..8)
DEFAULT_CODE, 32'h0000_1234, reset code, 4 bits per digit, digit 0 in bits [3:0] = last entered
UNLOCK_CYCLES, 36_000_000, unlock hold time (3 s at 12 MHz)
ERROR_CYCLES, 6_000_000, error indication time (0.5 s)
LOCKOUT_CYCLES, 120_000_000, lockout time (10 s)
ENTRY_TIMEOUT, 60_000_000, idle time between digits before a partial entry is discarded
MAX_FAILS, 3, consecutive mismatches that trigger lockout

Ports:
hwclk  in  1  system clock, 12 MHz, all logic on posedge
rst_n  in  1  asynchronous active-low reset
button  in  4  digit code from scanner, valid 1..9, held stable after a press
bstate  in  1  press strobe from scanner; a digit is accepted on its falling edge
set_code  in  1  program-mode switch level
unlocked  out  1  lock actuator drive, 1 = open
error  out  1  mismatch indication
lockout  out  1  lockout indication
code_saved  out  1  one-cycle pulse when a new code is stored
digit_count  out  3  digits collected in the current entry
state_dbg  out  3  current FSM state encoding

Behaviour:
- Reset (async assert, sync release): state ENTRY; all outputs 0; entry buffer 0; fail_cnt 0; stored code = DEFAULT_CODE low CODE_LEN*4 bits; timer 0.
- Digit event: bstate_q registered each cycle; digit_evt = bstate_q & ~bstate (exactly one cycle per press). button sampled in the digit_evt cycle. Values 0 or >9 ignored, with no count change.
- Entry buffer: shift left by 4 and insert the new digit at [3:0]. digit_count increments on the same edge as digit_evt. Comparison is over the full CODE_LEN*4 bits.
- States: ENTRY, CHECK, UNLOCKED, PROGRAM, FAIL, LOCKOUT.
- ENTRY:
  - Accept digits.
  - On the edge where digit_count reaches CODE_LEN, go to CHECK.
  - If digit_count>0 and ENTRY_TIMEOUT cycles pass with no digit_evt, clear buffer and count. No fail is recorded.
- CHECK (exactly 1 cycle). Buffer and count clear on exit.
  - Match: go to UNLOCKED, load timer UNLOCK_CYCLES, fail_cnt=0.
  - Mismatch with fail_cnt+1==MAX_FAILS: go to LOCKOUT, load LOCKOUT_CYCLES, fail_cnt=0.
  - Any other mismatch: fail_cnt++, go to FAIL, load ERROR_CYCLES.
- Registered outputs, asserted the cycle after entering a state:
  - unlocked = 1 in UNLOCKED and PROGRAM.
  - error = 1 in FAIL.
  - lockout = 1 in LOCKOUT.
- FAIL / LOCKOUT: digit_evt ignored. When the timer reaches 0, go to ENTRY. The state lasts exactly N cycles for a load of N.
- UNLOCKED:
  - Digits ignored; timer counts down; at 0 go to ENTRY.
  - set_code==1 takes priority over timer expiry in the same cycle: go to PROGRAM with timer frozen and count cleared.
- PROGRAM:
  - Collect digits as in ENTRY; no entry timeout.
  - On the CODE_LEN-th digit: stored code <= new buffer, code_saved pulses 1 cycle, go to ENTRY (locked).
  - set_code falling before completion: abort to ENTRY; stored code unchanged; no code_saved.
- The timer saturates at 0 and never wraps. fail_cnt is 0 after lockout. A successful unlock also clears fail_cnt.
- A digit_evt in the same cycle as the transition into CHECK cannot occur, because CHECK is entered on the completing digit. Any digit_evt during CHECK is dropped.
- Reset asserted mid-operation returns everything to reset values immediately, including a reprogrammed code reverting to DEFAULT_CODE.

Decomposition:
- Package code_lock_pkg holds: state enum (3-bit) and encodings mirrored on state_dbg; DIGIT_W=4; timer width = $clog2(LOCKOUT_CYCLES+1).
- Sub-module lock_timer: loadable down-counter with ports hwclk, rst_n, load, load_val, en, zero. It is shared by the unlock, error and lockout intervals. The entry-timeout counter is separate.

Test Plan:
Use reduced parameters: UNLOCK=20, ERROR=5, LOCKOUT=30, ENTRY_TIMEOUT=50, CODE_LEN=4, code 1234.
1. Pulse bstate with button 1,2,3,4 -> digit_count steps 1..4. CHECK for one cycle. unlocked=1 for exactly 20 cycles, then 0, state ENTRY.
2. Enter 1,2,3,5 -> error=1 for 5 cycles. Repeat twice more. The third mismatch gives lockout=1 for 30 cycles, error stays 0, and digits during lockout leave digit_count at 0.
3. Enter 1,2 then idle 50 cycles -> digit_count returns to 0. Then 1,2,3,4 unlocks with fail_cnt unaffected.
4. Unlock, raise set_code, enter 9,8,7,6 -> code_saved pulse once, unlocked=0. Entering 1,2,3,4 errors; 9,8,7,6 unlocks.
5. In PROGRAM, enter 5,5 then drop set_code -> ENTRY, no code_saved; 1,2,3,4 still unlocks.
6. Assert rst_n low mid-lockout and after reprogramming -> all outputs 0 immediately; 1,2,3,4 unlocks after release. Hold bstate high 100 cycles -> only one digit is accepted, on release.
